multicycle_control: RTL and testbench

- Finite-state control unit that sequences a multi-cycle RV32I-subset datapath around one shared instruction/data memory port.
- Supported instructions: LW, SW, R-type (ADD/SUB/AND/OR/SLL/SLT), I-type ALU, LUI, BEQ, BNE, JAL, JALR.
- Drives all datapath enables and mux selects, and the memory request handshake.
- Replaces the combinational decoder when the core runs in multi-cycle mode.

---
 rtl/mc_ctrl_pkg.sv | 57 +++++
 rtl/multicycle_control_if.sv | 31 +++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// State enum, opcode constants and the datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StLui, StAluWb, StBranch, StJal, StJalr, StJalrPc, StHalt
    } state_e;

    typedef enum logic [1:0] {AluOpAdd, AluOpSub, AluOpFunct} alu_op_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluAnd   = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluSll   = 3'b100;
    localparam logic [2:0] AluSlt   = 3'b101;
    localparam logic [2:0] AluPassB = 3'b111;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b100;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b001;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;

    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResRdata     = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            OpLui:    return ImmU;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: instruction/flag inputs, enables, selects, memory handshake.
interface multicycle_control_if;
    logic [31:0] Instr;
    logic        EQ;
    logic        mem_ready;
    logic        mem_req;
    logic        MemWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUctrl;
    logic [2:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic        retire;
    logic        illegal;

    modport master (
        input  Instr, EQ, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, ResultSrc, retire, illegal
    );

    modport slave (
        output Instr, EQ, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, ResultSrc, retire, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the op class and funct fields.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       opb5_i,
    output logic [2:0] alu_ctrl_o,
    output logic       bad_funct_o
);

    always_comb begin
        alu_ctrl_o  = AluAdd;
        bad_funct_o = 1'b0;
        case (alu_op_i)
            AluOpSub: alu_ctrl_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = (funct7b5_i && opb5_i) ? AluSub : AluAdd;
                    3'b001:  alu_ctrl_o = AluSll;
                    3'b010:  alu_ctrl_o = AluSlt;
                    3'b110:  alu_ctrl_o = AluOr;
                    3'b111:  alu_ctrl_o = AluAnd;
                    default: bad_funct_o = 1'b1;
                endcase
            end
            default: alu_ctrl_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencing an RV32I-subset datapath around one shared memory port.
// Outputs are Moore except the mem_ready- and EQ-gated PC/IR enables; all forced low in reset.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter bit RESET_HALT = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    alu_op_e    alu_op;
    logic [2:0] dec_alu_ctrl;
    logic       bad_funct;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire;
    logic [1:0] src_a, src_b, result_src;
    logic [2:0] alu_ctrl, imm_src;
    logic       unused_instr;

    assign opcode       = bus.Instr[6:0];
    assign funct3       = bus.Instr[14:12];
    assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

    always_comb begin
        unique case (opcode)
            OpRtype, OpItype: alu_op = AluOpFunct;
            OpBranch:         alu_op = AluOpSub;
            default:          alu_op = AluOpAdd;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i    (alu_op),
        .funct3_i    (funct3),
        .funct7b5_i  (bus.Instr[30]),
        .opb5_i      (bus.Instr[5]),
        .alu_ctrl_o  (dec_alu_ctrl),
        .bad_funct_o (bad_funct)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_HALT ? StHalt : StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        src_a      = SrcAPc;
        src_b      = SrcBRd2;
        alu_ctrl   = AluAdd;
        imm_src    = ImmI;
        result_src = ResAluOut;
        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                src_b      = SrcBFour;
                result_src = ResAluResult;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                src_a   = SrcAOldPc;
                src_b   = SrcBImm;
                imm_src = imm_src_of(opcode);
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = bad_funct ? StHalt : StExecR;
                    OpItype:         state_d = bad_funct ? StHalt : StExecI;
                    OpLui:           state_d = StLui;
                    OpBranch:        state_d = (funct3[2:1] == 2'b00) ? StBranch : StHalt;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    default:         state_d = StHalt;
                endcase
                if (state_d == StHalt) illegal_d = 1'b1;
            end
            StMemAdr: begin
                src_a    = SrcARd1;
                src_b    = SrcBImm;
                // Stores take their offset from the S-format immediate fields.
                imm_src  = imm_src_of(opcode);
                alu_ctrl = dec_alu_ctrl;
                state_d  = opcode[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResRdata;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR: begin
                src_a    = SrcARd1;
                src_b    = SrcBRd2;
                alu_ctrl = dec_alu_ctrl;
                state_d  = StAluWb;
            end
            StExecI: begin
                src_a    = SrcARd1;
                src_b    = SrcBImm;
                alu_ctrl = dec_alu_ctrl;
                state_d  = StAluWb;
            end
            StLui: begin
                src_b    = SrcBImm;
                imm_src  = ImmU;
                alu_ctrl = AluPassB;
                state_d  = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                src_a    = SrcARd1;
                src_b    = SrcBRd2;
                alu_ctrl = dec_alu_ctrl;
                retire   = 1'b1;
                // funct3[0] distinguishes BNE from BEQ.
                pc_write = bus.EQ ^ funct3[0];
                state_d  = StFetch;
            end
            StJal: begin
                pc_write = 1'b1;
                src_a    = SrcAOldPc;
                src_b    = SrcBFour;
                state_d  = StAluWb;
            end
            StJalr: begin
                src_a    = SrcARd1;
                src_b    = SrcBImm;
                alu_ctrl = dec_alu_ctrl;
                state_d  = StJalrPc;
            end
            StJalrPc: begin
                pc_write = 1'b1;
                src_a    = SrcAOldPc;
                src_b    = SrcBFour;
                state_d  = StAluWb;
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    assign bus.mem_req   = mem_req & ~rst;
    assign bus.MemWrite  = mem_write & ~rst;
    assign bus.AdrSrc    = adr_src & ~rst;
    assign bus.IRWrite   = ir_write & ~rst;
    assign bus.PCWrite   = pc_write & ~rst;
    assign bus.RegWrite  = reg_write & ~rst;
    assign bus.retire    = retire & ~rst;
    assign bus.illegal   = illegal_q & ~rst;
    assign bus.ALUSrcA   = rst ? 2'b00 : src_a;
    assign bus.ALUSrcB   = rst ? 2'b00 : src_b;
    assign bus.ALUctrl   = rst ? 3'b000 : alu_ctrl;
    assign bus.ImmSrc    = rst ? 3'b000 : imm_src;
    assign bus.ResultSrc = rst ? 2'b00 : result_src;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// instructions and wait states checked against a per-instruction behavioural model.
module tb_multicycle_control;

    logic clk, rst;
    int   n_cmp, n_bad;

    multicycle_control_if bus ();

    multicycle_control #(.RESET_HALT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] all_outs;
    assign all_outs = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
                       bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUctrl, bus.ImmSrc,
                       bus.ResultSrc, bus.retire, bus.illegal};

    typedef struct packed {
        int         cycles;
        int         retires;
        int         regw;
        int         regw_cyc;
        int         pcw;
        int         memreq;
        int         memwr;
        int         adrsrc;
        int         irw;
        logic [2:0] alu;
        logic [1:0] res;
        logic       ill;
        logic       timeout;
    } obs_t;

    // Expected per-instruction summary derived from the instruction set rules.
    function automatic obs_t model(input logic [31:0] instr, input int fw, input int mw,
                                   input logic eq);
        obs_t       e;
        logic [6:0] op = instr[6:0];
        logic [2:0] f3 = instr[14:12];
        bit         mem = 0, store = 0, rw = 0, load = 0;
        e = '0;
        e.alu = 3'b110;
        e.retires = 1;
        e.irw = 1;
        e.pcw = 1;
        e.memreq = fw + 1;
        case (op)
            7'b0000011: begin e.cycles = 5; mem = 1; load = 1; rw = 1; e.alu = 3'b000; end
            7'b0100011: begin e.cycles = 4; mem = 1; store = 1; e.alu = 3'b000; end
            7'b0110011, 7'b0010011: begin
                e.cycles = 4; rw = 1;
                case (f3)
                    3'b000:  e.alu = (op[5] && instr[30]) ? 3'b001 : 3'b000;
                    3'b001:  e.alu = 3'b100;
                    3'b010:  e.alu = 3'b101;
                    3'b110:  e.alu = 3'b011;
                    default: e.alu = 3'b010;
                endcase
            end
            7'b0110111: begin e.cycles = 4; rw = 1; e.alu = 3'b111; end
            7'b1100011: begin
                e.cycles = 3; e.alu = 3'b001;
                if (eq ^ f3[0]) e.pcw = 2;
            end
            7'b1101111: begin e.cycles = 4; rw = 1; e.pcw = 2; end
            default:    begin e.cycles = 5; rw = 1; e.pcw = 2; e.alu = 3'b000; end
        endcase
        e.cycles += fw + (mem ? mw : 0);
        if (mem) begin
            e.memreq += mw + 1;
            e.adrsrc = mw + 1;
            if (store) e.memwr = mw + 1;
        end
        if (rw) begin
            e.regw = 1;
            e.regw_cyc = e.cycles;
            e.res = load ? 2'b01 : 2'b00;
        end
        return e;
    endfunction

    // Runs one instruction from FETCH (entered at posedge+1) until retire, stalling each
    // memory access by the requested number of wait cycles.
    task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                             input logic eq, output obs_t o);
        int acc = 0, waited = 0;
        bit done = 0;
        o = '0;
        o.alu = 3'b110;
        bus.Instr = instr;
        bus.EQ = eq;
        for (int c = 1; c <= 60 && !done; c++) begin
            if (bus.mem_req) bus.mem_ready = (waited >= ((acc == 0) ? fw : mw));
            else bus.mem_ready = 1'($urandom);
            @(negedge clk);
            if (bus.mem_req) o.memreq++;
            if (bus.MemWrite) o.memwr++;
            if (bus.AdrSrc) o.adrsrc++;
            if (bus.IRWrite) o.irw++;
            if (bus.PCWrite) o.pcw++;
            if (bus.RegWrite) begin o.regw++; o.res = bus.ResultSrc; o.regw_cyc = c; end
            if (bus.ALUSrcA == 2'b10 || (bus.ALUSrcA == 2'b00 && bus.ALUSrcB == 2'b01))
                o.alu = bus.ALUctrl;
            if (bus.illegal) o.ill = 1'b1;
            if (bus.mem_req) begin
                if (bus.mem_ready) begin acc++; waited = 0; end
                else waited++;
            end
            if (bus.retire) begin o.retires++; o.cycles = c; done = 1; end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        if (!done) o.timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.EQ = 1'b1;
        bus.Instr = 32'h0050_0093;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (all_outs !== 20'h0) begin
            n_bad++; $display("FAIL reset_outs got=%h want=%h", all_outs, 20'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (all_outs !== {6'b100000, 2'b00, 2'b10, 3'b000, 3'b000, 2'b10, 2'b00}) begin
            n_bad++; $display("FAIL fetch_idle got=%b", all_outs);
        end
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.IRWrite, bus.PCWrite} !== 2'b11) begin
            n_bad++; $display("FAIL fetch_ready_en got=%b want=11", {bus.IRWrite, bus.PCWrite});
        end
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        obs_t o;
        run_instr(32'h0050_0093, 0, 0, 1'b0, o);
        n_cmp++;
        if (o.cycles !== 4 || o.timeout) begin
            n_bad++; $display("FAIL addi_cycles got=%0d want=4", o.cycles);
        end
        n_cmp++;
        if (o.regw !== 1 || o.regw_cyc !== 4 || o.res !== 2'b00) begin
            n_bad++; $display("FAIL addi_regwrite got=%0d@%0d res=%b want=1@4 res=00",
                              o.regw, o.regw_cyc, o.res);
        end
        n_cmp++;
        if (o.retires !== 1 || o.alu !== 3'b000) begin
            n_bad++; $display("FAIL addi_retire_alu got=%0d/%b want=1/000", o.retires, o.alu);
        end
    endtask

    task automatic test_lw_wait();
        obs_t o;
        run_instr(32'h0000_2083, 0, 2, 1'b0, o);
        n_cmp++;
        if (o.cycles !== 7) begin
            n_bad++; $display("FAIL lw_cycles got=%0d want=7", o.cycles);
        end
        n_cmp++;
        if (o.memreq !== 4 || o.adrsrc !== 3) begin
            n_bad++; $display("FAIL lw_req got=%0d/%0d want=4/3", o.memreq, o.adrsrc);
        end
        n_cmp++;
        if (o.regw !== 1 || o.res !== 2'b01) begin
            n_bad++; $display("FAIL lw_wb got=%0d res=%b want=1 res=01", o.regw, o.res);
        end
    endtask

    task automatic test_branches();
        obs_t        o;
        logic [31:0] instr;
        int          want_pcw;
        for (int i = 0; i < 4; i++) begin
            bit is_beq = (i >= 2);
            bit eq = i[0];
            instr = is_beq ? 32'h0000_0063 : 32'h0000_1063;
            want_pcw = 1 + ((is_beq ? eq : !eq) ? 1 : 0);
            run_instr(instr, 0, 0, eq, o);
            n_cmp++;
            if (o.cycles !== 3 || o.pcw !== want_pcw) begin
                n_bad++; $display("FAIL branch[%0d] got cyc=%0d pcw=%0d want cyc=3 pcw=%0d",
                                  i, o.cycles, o.pcw, want_pcw);
            end
        end
    endtask

    task automatic test_jalr();
        obs_t o;
        run_instr(32'h0000_80E7, 0, 0, 1'b0, o);
        n_cmp++;
        if (o.cycles !== 5 || o.pcw !== 2 || o.regw !== 1 || o.regw_cyc !== 5) begin
            n_bad++; $display("FAIL jalr got cyc=%0d pcw=%0d regw=%0d@%0d want 5/2/1@5",
                              o.cycles, o.pcw, o.regw, o.regw_cyc);
        end
    endtask

    task automatic test_random();
        obs_t        o, e;
        logic [31:0] r, instr;
        logic [2:0]  f3;
        logic        f7b5;
        logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        for (int n = 0; n < 80; n++) begin
            int fw = $urandom_range(0, 3);
            int mw = $urandom_range(0, 3);
            logic eq = 1'($urandom);
            r = $urandom;
            f3 = legal_f3[$urandom_range(0, 4)];
            f7b5 = (f3 == 3'b000) ? r[30] : 1'b0;
            case ($urandom_range(0, 7))
                0: instr = {r[31:15], 3'b010, r[11:7], 7'b0000011};
                1: instr = {r[31:15], 3'b010, r[11:7], 7'b0100011};
                2: instr = {1'b0, f7b5, 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
                3: instr = {r[31:15], f3, r[11:7], 7'b0010011};
                4: instr = {r[31:7], 7'b0110111};
                5: instr = {r[31:15], 2'b00, r[0], r[11:7], 7'b1100011};
                6: instr = {r[31:7], 7'b1101111};
                default: instr = {r[31:15], 3'b000, r[11:7], 7'b1100111};
            endcase
            e = model(instr, fw, mw, eq);
            run_instr(instr, fw, mw, eq, o);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rand[%0d] instr=%h fw=%0d mw=%0d eq=%b got cyc=%0d pcw=%0d rw=%0d@%0d res=%b req=%0d wr=%0d adr=%0d ir=%0d alu=%b ill=%b to=%b want cyc=%0d pcw=%0d rw=%0d@%0d res=%b req=%0d wr=%0d adr=%0d ir=%0d alu=%b",
                         n, instr, fw, mw, eq, o.cycles, o.pcw, o.regw, o.regw_cyc, o.res,
                         o.memreq, o.memwr, o.adrsrc, o.irw, o.alu, o.ill, o.timeout,
                         e.cycles, e.pcw, e.regw, e.regw_cyc, e.res, e.memreq, e.memwr,
                         e.adrsrc, e.irw, e.alu);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3] = '{32'h0000_007F, 32'h0000_B033, 32'h0000_2063};
        for (int i = 0; i < 3; i++) begin
            bus.Instr = bad[i];
            bus.mem_ready = 1'b1;
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            @(posedge clk); #1;
            for (int k = 0; k < 6; k++) begin
                bus.mem_ready = 1'($urandom);
                bus.EQ = 1'($urandom);
                @(negedge clk);
                n_cmp++;
                if (all_outs !== 20'h00001) begin
                    n_bad++; $display("FAIL halt[%0d] cyc%0d got=%b want only illegal", i, k,
                                      all_outs);
                end
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (all_outs !== 20'h0) begin
                n_bad++; $display("FAIL halt_rst[%0d] got=%h want=0", i, all_outs);
            end
            @(posedge clk); #1;
            rst = 1'b0;
            bus.mem_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({bus.mem_req, bus.illegal} !== 2'b10) begin
                n_bad++; $display("FAIL halt_exit[%0d] got=%b want=10", i,
                                  {bus.mem_req, bus.illegal});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_sw();
        obs_t o, e;
        bus.Instr = 32'h0000_2023;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.MemWrite, bus.AdrSrc} !== 3'b111) begin
            n_bad++; $display("FAIL sw_req got=%b want=111",
                              {bus.mem_req, bus.MemWrite, bus.AdrSrc});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (all_outs !== 20'h0) begin
            n_bad++; $display("FAIL sw_rst got=%h want=0", all_outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.illegal} !== 4'b1000) begin
            n_bad++; $display("FAIL sw_refetch got=%b want=1000",
                              {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.illegal});
        end
        @(posedge clk); #1;
        e = model(32'h0000_2023, 1, 1, 1'b0);
        run_instr(32'h0000_2023, 1, 1, 1'b0, o);
        n_cmp++;
        if (o !== e) begin
            n_bad++; $display("FAIL sw_after_rst got cyc=%0d wr=%0d want cyc=%0d wr=%0d",
                              o.cycles, o.memwr, e.cycles, e.memwr);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_addi();
        test_lw_wait();
        test_branches();
        test_jalr();
        test_random();
        test_illegal();
        test_reset_mid_sw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
